// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
//
// Contents:
//   SZ_B/SZ_H/SZ_W/SZ_D  access-size encoding (byte, half, word, dword)
//   state_t              stage FSM state
//   f_strobe             byte-enable pattern from size and lane offset
//   f_align_off          lane offset rounded down to the access size
package mem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Eight-lane pattern; narrower buses take the low bits.
   function automatic logic [7:0] f_strobe(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] ones;
      case (size)
         SZ_B:    ones = 8'h01;
         SZ_H:    ones = 8'h03;
         SZ_W:    ones = 8'h0F;
         default: ones = 8'hFF;
      endcase
      return ones << off;
   endfunction

   function automatic logic [2:0] f_align_off(input logic [1:0] size, input logic [2:0] off);
      logic [2:0] res;
      case (size)
         SZ_B:    res = off;
         SZ_H:    res = {off[2:1], 1'b0};
         SZ_W:    res = {off[2], 2'b00};
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational lane steering for the memory-access stage.
//
// Ports:
//   i_ld_size, i_ld_signed, i_ld_off  load size, sign-extend flag, lane offset
//   i_rdata                           full-width read data
//   o_ld_data                         extracted and extended load data
//   i_st_size, i_st_data              store size and right-justified data
//   o_st_data                         store data replicated across lanes
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int OFF_W = $clog2(DATA_W / 8)
) (
   input  logic [1:0]        i_ld_size,
   input  logic              i_ld_signed,
   input  logic [OFF_W-1:0]  i_ld_off,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_ld_data,
   input  logic [1:0]        i_st_size,
   input  logic [DATA_W-1:0] i_st_data,
   output logic [DATA_W-1:0] o_st_data
);

   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_keep;
   logic              w_ext;

   // Shift the addressed lane to bit 0, keep size-many low bytes and fill the
   // rest with the sign (or zero).
   always_comb begin
      w_shift = i_rdata >> {i_ld_off, 3'b000};
      w_keep  = {DATA_W{1'b1}};
      w_ext   = 1'b0;
      case (i_ld_size)
         SZ_B: begin
            w_keep = {DATA_W{1'b1}} >> (DATA_W - 8);
            w_ext  = w_shift[7];
         end
         SZ_H: begin
            w_keep = {DATA_W{1'b1}} >> (DATA_W - 16);
            w_ext  = w_shift[15];
         end
         SZ_W: begin
            w_keep = {DATA_W{1'b1}} >> (DATA_W - 32);
            w_ext  = w_shift[31];
         end
         default: begin
            w_keep = {DATA_W{1'b1}};
            w_ext  = w_shift[DATA_W-1];
         end
      endcase
      o_ld_data = (w_shift & w_keep) | ({DATA_W{i_ld_signed & w_ext}} & ~w_keep);
   end

   always_comb begin
      o_st_data = '0;
      case (i_st_size)
         SZ_B: for (int i = 0; i < DATA_W / 8; i++)  o_st_data[i*8 +: 8]   = i_st_data[7:0];
         SZ_H: for (int i = 0; i < DATA_W / 16; i++) o_st_data[i*16 +: 16] = i_st_data[15:0];
         SZ_W: for (int i = 0; i < DATA_W / 32; i++) o_st_data[i*32 +: 32] = i_st_data[31:0];
         default: o_st_data = i_st_data;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between EXU and WBU.
// Accepts one instruction per valid/ready handshake, runs loads/stores on a
// req/ack data bus with any number of wait states, and emits a one-cycle
// writeback beat. ALU-only instructions bypass the bus with 1-cycle latency.
//
// Optional feature macro: MEM_MISALIGN_EXC_EN
//   defined   -> misaligned accesses are not issued; exc_valid/exc_addr report them
//   undefined -> misaligned addresses are truncated to size alignment
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   in_*                          EXU instruction + handshake
//   mem_req/we/addr/wdata/wstrb   data-memory request
//   mem_ack, mem_rdata            data-memory response
//   exc_valid, exc_addr           misalignment report (macro only)
//   wb_valid/data/addr/wr         writeback beat to WBU
//
// state   | meaning
// IDLE    | ready for EXU; ALU-only ops retire from here
// BUSY    | memory request outstanding, waiting for mem_ack
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_AW = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_regc_data,
   input  logic [REG_AW-1:0]     in_regc_addr,
   input  logic                  in_regc_wr,
   input  logic                  in_mem_rd,
   input  logic                  in_mem_wr,
   input  logic [ADDR_W-1:0]     in_mem_addr,
   input  logic [DATA_W-1:0]     in_mem_data,
   input  logic [1:0]            in_size,
   input  logic                  in_signed,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
`ifdef MEM_MISALIGN_EXC_EN
   output logic                  exc_valid,
   output logic [ADDR_W-1:0]     exc_addr,
`endif
   output logic                  wb_valid,
   output logic [DATA_W-1:0]     wb_data,
   output logic [REG_AW-1:0]     wb_addr,
   output logic                  wb_wr
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic [1:0]          r_size;
   logic                r_signed;
   logic [OFF_W-1:0]    r_off;
   logic [REG_AW-1:0]   r_rd;
   logic                r_rd_wr;
   logic [DATA_W-1:0]   r_alu;

   logic                r_wb_valid;
   logic [DATA_W-1:0]   r_wb_data;
   logic [REG_AW-1:0]   r_wb_addr;
   logic                r_wb_wr;

   logic                w_xfer;
   logic                w_is_mem;
   logic                w_misalign;
   logic                w_ack;
   logic [2:0]          w_off3;
   logic [2:0]          w_aoff3;
   logic [OFF_W-1:0]    w_aoff;
   logic [7:0]          w_strb8;
   logic [DATA_W-1:0]   w_ld_data;
   logic [DATA_W-1:0]   w_st_data;

   assign w_xfer   = in_valid && (r_state == ST_IDLE);
   assign w_is_mem = in_mem_rd | in_mem_wr;
   assign w_ack    = (r_state == ST_BUSY) && mem_ack;

   assign w_off3  = 3'(in_mem_addr[OFF_W-1:0]);
   assign w_aoff3 = f_align_off(in_size, w_off3);
   assign w_aoff  = w_aoff3[OFF_W-1:0];
   assign w_strb8 = f_strobe(in_size, w_aoff3);

`ifdef MEM_MISALIGN_EXC_EN
   assign w_misalign = (w_aoff3 != w_off3);
`else
   assign w_misalign = 1'b0;
`endif

   mem_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .i_ld_size   (r_size),
      .i_ld_signed (r_signed),
      .i_ld_off    (r_off),
      .i_rdata     (mem_rdata),
      .o_ld_data   (w_ld_data),
      .i_st_size   (in_size),
      .i_st_data   (in_mem_data),
      .o_st_data   (w_st_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (w_xfer && w_is_mem && !w_misalign) w_state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (mem_ack) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request fields are captured at acceptance so the bus sees stable values
   // for however many wait states the memory inserts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_size   <= SZ_B;
         r_signed <= 1'b0;
         r_off    <= '0;
         r_rd     <= '0;
         r_rd_wr  <= 1'b0;
         r_alu    <= '0;
      end else if (w_xfer && w_is_mem && !w_misalign) begin
         r_we     <= in_mem_wr;
         r_addr   <= {in_mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         r_wdata  <= w_st_data;
         r_wstrb  <= in_mem_wr ? w_strb8[STRB_W-1:0] : {STRB_W{1'b1}};
         r_size   <= in_size;
         r_signed <= in_signed;
         r_off    <= w_aoff;
         r_rd     <= in_regc_addr;
         r_rd_wr  <= in_regc_wr;
         r_alu    <= in_regc_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_valid <= 1'b0;
         r_wb_data  <= '0;
         r_wb_addr  <= '0;
         r_wb_wr    <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
         exc_valid  <= 1'b0;
         exc_addr   <= '0;
`endif
      end else begin
         r_wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
         exc_valid  <= 1'b0;
`endif
         if (w_ack) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= r_we ? r_alu : w_ld_data;
            r_wb_addr  <= r_rd;
            r_wb_wr    <= r_rd_wr & ~r_we;
         end else if (w_xfer && !w_is_mem) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= in_regc_data;
            r_wb_addr  <= in_regc_addr;
            r_wb_wr    <= in_regc_wr;
         end
`ifdef MEM_MISALIGN_EXC_EN
         else if (w_xfer && w_misalign) begin
            // Faulting access retires as a non-writing beat alongside the report.
            r_wb_valid <= 1'b1;
            r_wb_data  <= in_regc_data;
            r_wb_addr  <= in_regc_addr;
            r_wb_wr    <= 1'b0;
            exc_valid  <= 1'b1;
            exc_addr   <= in_mem_addr;
         end
`endif
      end
   end

   // mem_req decodes straight from state so an async reset drops it at once.
   assign mem_req   = (r_state == ST_BUSY);
   assign mem_we    = r_we & mem_req;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wstrb = r_wstrb;

   assign wb_valid  = r_wb_valid;
   assign wb_data   = r_wb_data;
   assign wb_addr   = r_wb_addr;
   assign wb_wr     = r_wb_wr;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage between EXU and WBU of the MIPS core. Registers one instruction from EXU per valid/ready handshake, issues a byte/half/word(/dword) load or store on a variable-latency req/ack data-memory bus, aligns and extends load data, and presents a single-cycle writeback beat to WBU. ALU-only instructions pass through with one-cycle latency. Unlike the previous fixed-latency stage, it supports memory wait states, sub-word access and back-pressure to EXU.

## Interface
Parameters:
- DATA_W, 32, data bus width; legal values are 32 and 64.
- ADDR_W, 32, memory address width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EXU holds a valid instruction.
- in_ready  out  1  stage accepts; a transfer occurs when in_valid && in_ready.
- in_regc_data  in  DATA_W  ALU result for writeback.
- in_regc_addr  in  REG_AW  destination register.
- in_regc_wr  in  1  register write enable.
- in_mem_rd  in  1  load.
- in_mem_wr  in  1  store; if both in_mem_rd and in_mem_wr are set, the store wins.
- in_mem_addr  in  ADDR_W  byte address.
- in_mem_data  in  DATA_W  store data, right-justified.
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword is legal only when DATA_W=64).
- in_signed  in  1  sign-extend loads.
- mem_req  out  1  access request.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  address, lane bits forced to 0.
- mem_wdata  out  DATA_W  store data replicated across lanes.
- mem_wstrb  out  DATA_W/8  byte enables; all ones for loads.
- mem_ack  in  1  access complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  full-width read data.
- wb_valid  out  1  one-cycle writeback beat.
- wb_data  out  DATA_W  aligned load data or ALU result.
- wb_addr  out  REG_AW  destination register.
- wb_wr  out  1  register write; qualified by wb_valid.

## Operation
- The FSM has two states: IDLE and BUSY. in_ready = (state == IDLE).
- IDLE, on a transfer:
  - Load or store: capture all fields, then go to BUSY.
  - ALU-only: load the wb registers directly and stay in IDLE.
- BUSY:
  - mem_req = 1. mem_we, mem_addr, mem_wdata and mem_wstrb come from registers and stay stable until acknowledged.
  - On mem_ack: a load's wb_data is lane-extracted from mem_rdata using addr[log2(DATA_W/8)-1:0] and the size, then zero- or sign-extended to DATA_W. A store forces wb_wr = 0. wb_valid is set and the state returns to IDLE.
- Store lanes: byte, half and word data are replicated to fill DATA_W. The strobe has size-many ones, shifted by the lane offset.
- mem_ack while mem_req = 0 is ignored.
- Reset values: state IDLE; mem_req, mem_we, wb_valid and wb_wr are 0; all data, address and strobe outputs are 0; in_ready is 1 once reset is released. Asserting reset mid-access drops mem_req immediately and discards the access. An ack arriving after reset is ignored.

## Timing
- ALU-only: a transfer at edge T gives wb_valid high for the cycle after T. Sustains 1 instruction per cycle.
- Load/store: a transfer at edge T0 raises mem_req in the cycle after T0. With ack sampled at edge T1, wb_valid is high in the cycle after T1.
  - Minimum latency is 2 cycles, reached with a same-cycle ack.
  - Throughput is 1 access per (2 + wait) cycles.
- wb_valid is a single-cycle pulse. WBU cannot stall this stage.
- A new instruction may be accepted in the same cycle that wb_valid is high.

## Configuration
- MEM_MISALIGN_EXC_EN defined:
  - Adds outputs exc_valid (1 bit) and exc_addr (ADDR_W).
  - A load or store whose address is not size-aligned never enters BUSY and never raises mem_req.
  - Instead, the cycle after acceptance has exc_valid = 1, exc_addr = the faulting address, wb_valid = 1 and wb_wr = 0.
  - Reset value of both outputs is 0.
- Macro undefined: the exc ports are absent. Misaligned addresses are silently truncated to size alignment and the access proceeds.

## Structure
- Package mem_pkg holds:
  - the size encoding constants SZ_B, SZ_H, SZ_W, SZ_D;
  - the FSM state typedef;
  - the function computing the strobe from size and offset.
- Sub-module mem_lane_align is combinational and parametrised by DATA_W. It performs load extract/extend and store replication. It is instantiated once and unit-tested on its own.

## Test plan
- ALU-only back-to-back: three transfers in consecutive cycles with regc_data 0x11/0x22/0x33 -> wb_valid on three consecutive cycles, with wb_data matching in order.
- Signed byte load: addr 0x1003, size 0, signed, rdata 0x80FF_FF7F -> wb_data 0xFFFF_FF80. The same access unsigned -> 0x0000_0080.
- Half store with 3 wait states: addr 0x2002, data 0xBEEF -> mem_wdata 0xBEEF_BEEF and mem_wstrb 0b1100, all held for 4 req cycles; in_ready low throughout; wb_valid with wb_wr = 0 the cycle after ack.
- Reset mid-access: drop rst while BUSY, then ack in the next cycle -> mem_req goes to 0 asynchronously, no wb_valid, and in_ready is 1 after release.
- Misaligned word load at 0x3001: with MEM_MISALIGN_EXC_EN -> no mem_req, exc_valid pulse with exc_addr 0x3001. Without the macro -> mem_addr 0x3000 and a normal load.
- DATA_W=64 dword load at 0x8 -> mem_wstrb 0xFF and wb_data equal to mem_rdata.
